// File: rtl/vram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vram_controller
//  Description : Single-port asynchronous SRAM front end for a 640x480 video
//                pipeline. Every cycle it turns a requested pixel coordinate
//                (background plane or sprite sheet) into an SRAM word read and
//                returns the selected byte as an RRRGGGBB pixel two clocks
//                later. Outside the active display area it can optionally
//                service a word write from a second requester.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//    VRAM_WR_PORT_EN  defined   -> write port active (RD/WR_SETUP/WR_PULSE)
//                     undefined -> read-only, WR_* inputs are ignored
// ----------------------------------------------------------------------------
//  Ports:
//    CLK               in   1   memory clock, the only clock
//    RESET_N           in   1   asynchronous active-low reset
//    VRAM_READ_SPRITE  in   1   1 = sprite sheet, 0 = background
//    VRAM_X, VRAM_Y    in  10   requested pixel coordinate
//    VRAM_RGB          out  8   returned pixel (0 during blanking)
//    WR_REQ            in   1   write request, held until WR_ACK
//    WR_ADDR           in  20   write word address
//    WR_DATA           in  16   write data
//    WR_ACK            out  1   one-cycle write-complete pulse
//    SRAM_ADDR         out 20   SRAM word address
//    SRAM_DQ_IN        in  16   SRAM read data
//    SRAM_DQ_OUT       out 16   SRAM write data
//    SRAM_DQ_OE        out  1   DQ drive enable
//    SRAM_CE_N/OE_N/WE_N/UB_N/LB_N  out 1  active-low SRAM strobes
// ============================================================================
module vram_controller #(
    parameter logic [20:0] BG_BASE        = 21'd0,
    parameter logic [20:0] SPRITE_BASE    = 21'h4B000,
    parameter logic [10:0] SPRITE_SHEET_W = 11'd1024
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        VRAM_READ_SPRITE,
    input  logic [9:0]  VRAM_X,
    input  logic [9:0]  VRAM_Y,
    output logic [7:0]  VRAM_RGB,
    input  logic        WR_REQ,
    input  logic [19:0] WR_ADDR,
    input  logic [15:0] WR_DATA,
    output logic        WR_ACK,
    output logic [19:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_IN,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [9:0]  c_h_active = 10'd640;
    localparam logic [9:0]  c_v_active = 10'd480;
    localparam logic [20:0] c_bg_pitch = 21'd640;

    typedef enum logic [1:0] {
        RD       = 2'd0,
        WR_SETUP = 2'd1,
        WR_PULSE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        spr_q, spr_d;
    logic [7:0]  rgb_q, rgb_d;

    logic [20:0] w_row_bg;
    logic [20:0] w_row_spr;
    logic [20:0] w_index;
    logic        w_blank;
    logic [7:0]  w_byte;

    logic [19:0] w_addr;
    logic [15:0] w_dq_out;
    logic        w_dq_oe;
    logic        w_oe_n;
    logic        w_we_n;
    logic        w_ack;

`ifndef VRAM_WR_PORT_EN
    // Write inputs have no function in the read-only build.
    logic w_unused_wr;
    assign w_unused_wr = ^{WR_REQ, WR_ADDR, WR_DATA};
`endif

    // ------------------------------------------------------------------------
    // Pixel index arithmetic, all modulo 2^21.
    // ------------------------------------------------------------------------
    assign w_row_bg  = {11'd0, y_q} * c_bg_pitch;
    assign w_row_spr = {11'd0, y_q} * {10'd0, SPRITE_SHEET_W};
    assign w_index   = spr_q ? (SPRITE_BASE + w_row_spr + {11'd0, x_q})
                             : (BG_BASE     + w_row_bg  + {11'd0, x_q});

    assign w_blank = (x_q >= c_h_active) || (y_q >= c_v_active);

    // Two pixels per 16-bit word; odd pixels live in the upper byte.
    assign w_byte = w_index[0] ? SRAM_DQ_IN[15:8] : SRAM_DQ_IN[7:0];

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        x_d      = VRAM_X;
        y_d      = VRAM_Y;
        spr_d    = VRAM_READ_SPRITE;
        state_d  = state_q;
        rgb_d    = rgb_q;
        w_addr   = w_index[20:1];
        w_dq_out = 16'h0000;
        w_dq_oe  = 1'b0;
        w_oe_n   = 1'b1;
        w_we_n   = 1'b1;
        w_ack    = 1'b0;

        case (state_q)
            RD: begin
                w_oe_n = 1'b0;
                rgb_d  = w_blank ? 8'h00 : w_byte;
`ifdef VRAM_WR_PORT_EN
                // Writes may only steal the SRAM while the display is blank.
                if (WR_REQ && w_blank) begin
                    state_d = WR_SETUP;
                end
`endif
            end
`ifdef VRAM_WR_PORT_EN
            WR_SETUP: begin
                // Address and data settle one cycle before WE_N falls.
                w_addr   = WR_ADDR;
                w_dq_out = WR_DATA;
                w_dq_oe  = 1'b1;
                state_d  = WR_PULSE;
            end
            WR_PULSE: begin
                w_addr   = WR_ADDR;
                w_dq_out = WR_DATA;
                w_dq_oe  = 1'b1;
                w_we_n   = 1'b0;
                w_ack    = 1'b1;
                state_d  = RD;
            end
`endif
            default: begin
                state_d = RD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RD;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            spr_q   <= 1'b0;
            rgb_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            spr_q   <= spr_d;
            rgb_q   <= rgb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. CE_N and OE_N are gated with RESET_N so the SRAM is deselected
    // the instant reset asserts; WE_N/DQ_OE/WR_ACK follow the state register,
    // which is itself cleared asynchronously.
    // ------------------------------------------------------------------------
    assign VRAM_RGB    = rgb_q;
    assign WR_ACK      = w_ack;
    assign SRAM_ADDR   = w_addr;
    assign SRAM_DQ_OUT = w_dq_out;
    assign SRAM_DQ_OE  = w_dq_oe;
    assign SRAM_CE_N   = ~RESET_N;
    assign SRAM_OE_N   = w_oe_n | ~RESET_N;
    assign SRAM_WE_N   = w_we_n;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_controller
//  Description : Self-checking bench for vram_controller with a behavioural
//                asynchronous SRAM model. Write-port sequences are built only
//                when VRAM_WR_PORT_EN is defined; otherwise the read-only
//                behaviour under a held write request is checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_controller;

    logic        CLK;
    logic        RESET_N;
    logic        VRAM_READ_SPRITE;
    logic [9:0]  VRAM_X;
    logic [9:0]  VRAM_Y;
    logic [7:0]  VRAM_RGB;
    logic        WR_REQ;
    logic [19:0] WR_ADDR;
    logic [15:0] WR_DATA;
    logic        WR_ACK;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_IN;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    int checks = 0;
    int errors = 0;

    vram_controller dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .VRAM_READ_SPRITE (VRAM_READ_SPRITE),
        .VRAM_X           (VRAM_X),
        .VRAM_Y           (VRAM_Y),
        .VRAM_RGB         (VRAM_RGB),
        .WR_REQ           (WR_REQ),
        .WR_ADDR          (WR_ADDR),
        .WR_DATA          (WR_DATA),
        .WR_ACK           (WR_ACK),
        .SRAM_ADDR        (SRAM_ADDR),
        .SRAM_DQ_IN       (SRAM_DQ_IN),
        .SRAM_DQ_OUT      (SRAM_DQ_OUT),
        .SRAM_DQ_OE       (SRAM_DQ_OE),
        .SRAM_CE_N        (SRAM_CE_N),
        .SRAM_OE_N        (SRAM_OE_N),
        .SRAM_WE_N        (SRAM_WE_N),
        .SRAM_UB_N        (SRAM_UB_N),
        .SRAM_LB_N        (SRAM_LB_N)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------------
    // SRAM model: explicit contents where written/preloaded, otherwise a
    // fixed address-derived pattern (addr[15:0] ^ 16'h5A5A).
    // ------------------------------------------------------------------------
    logic [15:0] mem [logic [19:0]];

    function automatic logic [15:0] mem_read(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        #1;
        SRAM_DQ_IN = mem_read(SRAM_ADDR);
    end

    always @(negedge CLK) begin
        if (!SRAM_WE_N && !SRAM_CE_N && SRAM_DQ_OE) mem[SRAM_ADDR] = SRAM_DQ_OUT;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge two clocks later.
    task automatic apply(input string nm, input logic [9:0] x, input logic [9:0] y,
                         input logic s, input logic [19:0] ea, input logic [7:0] er);
        VRAM_X = x;
        VRAM_Y = y;
        VRAM_READ_SPRITE = s;
        @(negedge CLK);
        chk({nm, " addr"}, {12'd0, SRAM_ADDR}, {12'd0, ea});
        chk({nm, " strobes"}, {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N},
            {27'd0, 5'b00100});
        @(negedge CLK);
        chk({nm, " rgb"}, {24'd0, VRAM_RGB}, {24'd0, er});
    endtask

`ifdef VRAM_WR_PORT_EN
    task automatic wait_ack(input string nm, input int max);
        int n;
        n = 0;
        @(negedge CLK);
        while (!WR_ACK && n < max) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, " ack seen"}, {31'd0, WR_ACK}, 32'd1);
    endtask
`endif

    typedef struct {
        string       nm;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        spr;
        logic [19:0] addr;
        logic [7:0]  rgb;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[20'h00000] = 16'hA55A;
        mem[20'h25A01] = 16'hC37E;

        vecs[0] = '{"bg_0_0",      10'd0,    10'd0,    1'b0, 20'h00000, 8'h5A};
        vecs[1] = '{"spr_3_1",     10'd3,    10'd1,    1'b1, 20'h25A01, 8'hC3};
        vecs[2] = '{"bg_1_0",      10'd1,    10'd0,    1'b0, 20'h00000, 8'hA5};
        vecs[3] = '{"bg_5_2",      10'd5,    10'd2,    1'b0, 20'h00282, 8'h58};
        vecs[4] = '{"bg_639_479",  10'd639,  10'd479,  1'b0, 20'h257FF, 8'h0D};
        vecs[5] = '{"blank_x640",  10'd640,  10'd0,    1'b0, 20'h00140, 8'h00};
        vecs[6] = '{"blank_y480",  10'd0,    10'd480,  1'b0, 20'h25800, 8'h00};
        vecs[7] = '{"spr_100_10",  10'd100,  10'd10,   1'b1, 20'h26C32, 8'h68};

        VRAM_X = 10'd0;
        VRAM_Y = 10'd0;
        VRAM_READ_SPRITE = 1'b0;
        WR_REQ = 1'b0;
        WR_ADDR = 20'd0;
        WR_DATA = 16'd0;
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        #2;
        chk("reset rgb", {24'd0, VRAM_RGB}, 32'd0);
        chk("reset ack", {31'd0, WR_ACK}, 32'd0);
        chk("reset strobes", {28'd0, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N},
            {28'd0, 4'b0111});

        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].nm, vecs[i].x, vecs[i].y, vecs[i].spr, vecs[i].addr, vecs[i].rgb);
        end

        // Reset in the middle of a visible read clears the pixel at once.
        apply("pre_reset", 10'd0, 10'd0, 1'b0, 20'h00000, 8'h5A);
        #2 RESET_N = 1'b0;
        #1;
        chk("async reset rgb", {24'd0, VRAM_RGB}, 32'd0);
        chk("async reset ce/oe", {30'd0, SRAM_CE_N, SRAM_OE_N}, {30'd0, 2'b11});
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("post reset oe", {31'd0, SRAM_OE_N}, 32'd0);

`ifdef VRAM_WR_PORT_EN
        // Held request during active video is not served.
        VRAM_X = 10'd100;
        WR_REQ = 1'b1;
        WR_ADDR = 20'h00010;
        WR_DATA = 16'h1234;
        repeat (4) begin
            @(negedge CLK);
            chk("visible no write", {30'd0, WR_ACK, SRAM_WE_N}, {30'd0, 2'b01});
        end
        VRAM_X = 10'd640;
        @(negedge CLK);
        chk("blank first cycle RD", {30'd0, WR_ACK, SRAM_DQ_OE}, 32'd0);
        @(negedge CLK);
        chk("setup strobes", {28'd0, SRAM_DQ_OE, SRAM_OE_N, SRAM_WE_N, WR_ACK},
            {28'd0, 4'b1110});
        chk("setup addr", {12'd0, SRAM_ADDR}, 32'h10);
        chk("setup data", {16'd0, SRAM_DQ_OUT}, 32'h1234);
        VRAM_X = 10'd32;    // leave blanking mid-write
        @(negedge CLK);
        chk("pulse we/ack", {30'd0, SRAM_WE_N, WR_ACK}, {30'd0, 2'b01});
        chk("pulse addr", {12'd0, SRAM_ADDR}, 32'h10);
        chk("pulse rgb held", {24'd0, VRAM_RGB}, 32'd0);
        WR_REQ = 1'b0;
        @(negedge CLK);
        chk("after write RD", {29'd0, WR_ACK, SRAM_WE_N, SRAM_OE_N}, {29'd0, 3'b010});
        chk("after write rgb held", {24'd0, VRAM_RGB}, 32'd0);
        @(negedge CLK);
        chk("first read after write", {24'd0, VRAM_RGB}, 32'h34);
        apply("rd_32", 10'd32, 10'd0, 1'b0, 20'h00010, 8'h34);
        apply("rd_33", 10'd33, 10'd0, 1'b0, 20'h00010, 8'h12);

        // Two writes queued one behind the other.
        VRAM_X = 10'd700;
        WR_REQ = 1'b1;
        WR_ADDR = 20'h00020;
        WR_DATA = 16'hBEEF;
        wait_ack("b2b first", 8);
        WR_ADDR = 20'h00021;
        WR_DATA = 16'hCAFE;
        wait_ack("b2b second", 8);
        WR_REQ = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("no extra ack", {31'd0, WR_ACK}, 32'd0);
        end
        apply("rd_64", 10'd64, 10'd0, 1'b0, 20'h00020, 8'hEF);
        apply("rd_67", 10'd67, 10'd0, 1'b0, 20'h00021, 8'hCA);

        // Reset during the write pulse aborts it immediately.
        VRAM_X = 10'd640;
        WR_REQ = 1'b1;
        WR_ADDR = 20'h00030;
        WR_DATA = 16'h5555;
        wait_ack("pre-abort", 8);
        RESET_N = 1'b0;
        #1;
        chk("abort we/ack", {30'd0, SRAM_WE_N, WR_ACK}, {30'd0, 2'b10});
        chk("abort dq_oe/ce", {30'd0, SRAM_DQ_OE, SRAM_CE_N}, {30'd0, 2'b01});
        chk("abort rgb", {24'd0, VRAM_RGB}, 32'd0);
        WR_REQ = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("abort resume RD", {29'd0, SRAM_OE_N, SRAM_WE_N, WR_ACK}, {29'd0, 3'b010});
`else
        // Read-only build: a held request in blanking is never served.
        VRAM_X = 10'd640;
        WR_REQ = 1'b1;
        WR_ADDR = 20'h00010;
        WR_DATA = 16'h1234;
        repeat (100) begin
            @(negedge CLK);
            chk("ro ack/we/oe", {29'd0, WR_ACK, SRAM_WE_N, SRAM_DQ_OE}, {29'd0, 3'b010});
        end
        WR_REQ = 1'b0;
        apply("ro_rd_32", 10'd32, 10'd0, 1'b0, 20'h00010, 8'h4A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
